// File: rtl/sdram_responder.sv
// Device-side SDRAM model: decodes controller pins, serves reads/writes from an
// on-chip word array and raises sticky flags on protocol timing violations.
module sdram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 9,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7,
    parameter int T_MRD    = 2
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        sd_cke,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_a,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic [1:0]  sd_dq_oe,
    output logic        ready,
    output logic [1:0]  cas_lat,
    output logic [3:0]  err,
    output logic [15:0] refresh_cnt
);

    localparam int IDX_W = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << IDX_W;

    // Timers hold "cycles still blocked": loaded with T-1 at the command edge.
    localparam logic [3:0] RCD_LD = 4'(T_RCD - 1);
    localparam logic [3:0] RP_LD  = 4'(T_RP - 1);
    localparam logic [3:0] RFC_LD = 4'(T_RFC - 1);
    localparam logic [3:0] MRD_LD = 4'(T_MRD - 1);

    typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_MRS} cmd_t;
    typedef enum logic [1:0] {S_WAIT_PRE, S_WAIT_REF, S_WAIT_MODE, S_READY} state_t;

    cmd_t        cmd;
    state_t      state, state_nx;
    logic        ref_seen, ref_seen_nx;

    logic [3:0]  bank_open;
    logic [12:0] bank_row [4];
    logic [3:0]  bank_tmr [4];
    logic [3:0]  glob_tmr;
    logic        glob_mrd;

    logic [15:0] mem [DEPTH];
    logic [IDX_W-1:0] mem_idx;
    logic [15:0] rd_word;
    logic        rw_cmd, access, wr_en, rd_en, mode_ok;
    logic [3:0]  err_set;

    logic [15:0] rd_data_p0, rd_data_p1;
    logic [1:0]  rd_oe_p0, rd_oe_p1;
    logic        vld_p0, vld_p1;
    logic        unused_bits;

    always_comb begin
        cmd = C_NOP;
        if (sd_cke && !sd_ncs) begin
            case ({sd_nras, sd_ncas, sd_nwe})
                3'b011:  cmd = C_ACT;
                3'b101:  cmd = C_RD;
                3'b100:  cmd = C_WR;
                3'b010:  cmd = C_PRE;
                3'b001:  cmd = C_REF;
                3'b000:  cmd = C_MRS;
                default: cmd = C_NOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state    <= S_WAIT_PRE;
            ref_seen <= 1'b0;
        end else begin
            state    <= state_nx;
            ref_seen <= ref_seen_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        ref_seen_nx = ref_seen;
        case (state)
            S_WAIT_PRE: begin
                ref_seen_nx = 1'b0;
                if (cmd == C_PRE && sd_a[10]) state_nx = S_WAIT_REF;
            end
            S_WAIT_REF: begin
                if (cmd == C_REF) begin
                    ref_seen_nx = 1'b1;
                    if (ref_seen) state_nx = S_WAIT_MODE;
                end
            end
            S_WAIT_MODE: if (cmd == C_MRS) state_nx = S_READY;
            default: state_nx = S_READY;
        endcase
    end

    always_comb begin
        ready = (state == S_READY);
    end

    always_comb begin
        mem_idx = {sd_ba, bank_row[sd_ba][ROW_BITS-1:0], sd_a[COL_BITS-1:0]};
        rd_word = mem[mem_idx];
        rw_cmd  = (cmd == C_RD) || (cmd == C_WR);
        access  = ready && rw_cmd && bank_open[sd_ba];
        wr_en   = access && (cmd == C_WR);
        rd_en   = access && (cmd == C_RD);
        mode_ok = (sd_a[5:4] == 2'd2 || sd_a[5:4] == 2'd3) && (sd_a[2:0] == 3'b000);

        err_set = 4'b0000;
        if (cmd != C_NOP && glob_tmr != 4'd0) begin
            if (glob_mrd) err_set[3] = 1'b1;
            else          err_set[2] = 1'b1;
        end
        if (!ready && (cmd == C_ACT || rw_cmd)) err_set[3] = 1'b1;
        if (ready && cmd == C_ACT) begin
            if (bank_open[sd_ba])               err_set[0] = 1'b1;
            else if (bank_tmr[sd_ba] != 4'd0)   err_set[2] = 1'b1;
        end
        if (ready && rw_cmd) begin
            if (!bank_open[sd_ba])              err_set[0] = 1'b1;
            else if (bank_tmr[sd_ba] != 4'd0)   err_set[1] = 1'b1;
        end
        if (cmd == C_REF && |bank_open) err_set[0] = 1'b1;
        if (cmd == C_MRS && !mode_ok)   err_set[3] = 1'b1;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            bank_open   <= 4'b0000;
            for (int b = 0; b < 4; b++) bank_tmr[b] <= 4'd0;
            glob_tmr    <= 4'd0;
            glob_mrd    <= 1'b0;
            err         <= 4'b0000;
            refresh_cnt <= 16'd0;
            cas_lat     <= 2'd2;
        end else begin
            err <= err | err_set;
            if (glob_tmr != 4'd0) glob_tmr <= glob_tmr - 4'd1;
            for (int b = 0; b < 4; b++) begin
                if (bank_tmr[b] != 4'd0) bank_tmr[b] <= bank_tmr[b] - 4'd1;
            end
            case (cmd)
                C_ACT: begin
                    if (ready) begin
                        bank_open[sd_ba] <= 1'b1;
                        bank_tmr[sd_ba]  <= RCD_LD;
                    end
                end
                C_RD, C_WR: begin
                    if (access && sd_a[10]) begin
                        bank_open[sd_ba] <= 1'b0;
                        bank_tmr[sd_ba]  <= RP_LD;
                    end
                end
                C_PRE: begin
                    for (int b = 0; b < 4; b++) begin
                        if (sd_a[10] || sd_ba == 2'(b)) begin
                            bank_open[b] <= 1'b0;
                            bank_tmr[b]  <= RP_LD;
                        end
                    end
                end
                C_REF: begin
                    glob_tmr <= RFC_LD;
                    glob_mrd <= 1'b0;
                    if (refresh_cnt != 16'hFFFF) refresh_cnt <= refresh_cnt + 16'd1;
                end
                C_MRS: begin
                    glob_tmr <= MRD_LD;
                    glob_mrd <= 1'b1;
                    cas_lat  <= mode_ok ? sd_a[5:4] : 2'd3;
                end
                default: ;
            endcase
        end
    end

    // Row latches and backing store are data only and survive reset.
    always_ff @(posedge clk) begin
        if (cmd == C_ACT && ready) bank_row[sd_ba] <= sd_a;
        if (wr_en) begin
            if (!sd_dqml) mem[mem_idx][7:0]  <= sd_dq_in[7:0];
            if (!sd_dqmh) mem[mem_idx][15:8] <= sd_dq_in[15:8];
        end
    end

    // Read stage p0: extra delay slot used only at CL3
    always_ff @(posedge clk) begin
        if (rd_en) rd_data_p0 <= rd_word;
        rd_data_p1 <= (rd_en && cas_lat != 2'd3) ? rd_word : rd_data_p0;
    end

    // Read stage p1 -> pin register, valid for exactly one cycle
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            rd_oe_p0  <= 2'b00;
            rd_oe_p1  <= 2'b00;
            sd_dq_oe  <= 2'b00;
            sd_dq_out <= 16'd0;
        end else begin
            vld_p0   <= rd_en && (cas_lat == 2'd3);
            rd_oe_p0 <= ~{sd_dqmh, sd_dqml};
            vld_p1   <= (rd_en && cas_lat != 2'd3) || vld_p0;
            rd_oe_p1 <= (rd_en && cas_lat != 2'd3) ? ~{sd_dqmh, sd_dqml} : rd_oe_p0;
            sd_dq_oe  <= vld_p1 ? rd_oe_p1 : 2'b00;
            sd_dq_out <= vld_p1 ? rd_data_p1 : 16'd0;
        end
    end

    assign unused_bits = ^{bank_row[0], bank_row[1], bank_row[2], bank_row[3], sd_a};

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: driver issues commands and queues expected
// read words; a negedge monitor pops and compares whatever the pins present.
module tb_sdram_responder;

    logic        clk = 1'b0;
    logic        init_n;
    logic        sd_cke, sd_ncs, sd_nras, sd_ncas, sd_nwe;
    logic [1:0]  sd_ba;
    logic [12:0] sd_a;
    logic        sd_dqml, sd_dqmh;
    logic [15:0] sd_dq_in;
    logic [15:0] sd_dq_out;
    logic [1:0]  sd_dq_oe;
    logic        ready;
    logic [1:0]  cas_lat;
    logic [3:0]  err;
    logic [15:0] refresh_cnt;

    localparam logic [3:0] C_NOP = 4'b1111, C_ACT = 4'b0011, C_RD = 4'b0101,
                           C_WR = 4'b0100, C_PRE = 4'b0010, C_REF = 4'b0001,
                           C_MRS = 4'b0000;

    typedef struct {
        int unsigned cyc;
        logic [15:0] data;
        logic [1:0]  oe;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned last_edge = 0;
    int          checks = 0;
    int          errors = 0;

    sdram_responder dut (
        .clk(clk), .init_n(init_n), .sd_cke(sd_cke), .sd_ncs(sd_ncs),
        .sd_nras(sd_nras), .sd_ncas(sd_ncas), .sd_nwe(sd_nwe), .sd_ba(sd_ba),
        .sd_a(sd_a), .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh), .sd_dq_in(sd_dq_in),
        .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe), .ready(ready),
        .cas_lat(cas_lat), .err(err), .refresh_cnt(refresh_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] dq, input logic [1:0] dqm);
        {sd_ncs, sd_nras, sd_ncas, sd_nwe} = c;
        sd_ba = ba; sd_a = a; sd_dq_in = dq;
        {sd_dqmh, sd_dqml} = dqm;
        last_edge = cyc + 1;
        @(posedge clk);
        #1;
        {sd_ncs, sd_nras, sd_ncas, sd_nwe} = C_NOP;
        {sd_dqmh, sd_dqml} = 2'b00;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [12:0] col, input logic [1:0] dqm,
                      input logic [15:0] data, input int cl);
        exp_t e;
        issue(C_RD, ba, col, 16'd0, dqm);
        e.cyc  = last_edge + 32'(cl) - 1;
        e.data = data;
        e.oe   = ~dqm;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] m;
        if (sd_dq_oe != 2'b00) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: cycle %0d oe=%b data=%h, required no output",
                         cyc, sd_dq_oe, sd_dq_out);
            end else begin
                e = q.pop_front();
                m = {{8{e.oe[1]}}, {8{e.oe[0]}}};
                if (cyc != e.cyc || sd_dq_oe != e.oe || (sd_dq_out & m) != (e.data & m)) begin
                    errors++;
                    $display("FAIL rd_data: got cycle %0d oe=%b data=%h, required cycle %0d oe=%b data=%h",
                             cyc, sd_dq_oe, sd_dq_out, e.cyc, e.oe, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        init_n = 1'b0; sd_cke = 1'b1;
        {sd_ncs, sd_nras, sd_ncas, sd_nwe} = C_NOP;
        sd_ba = 2'd0; sd_a = 13'd0; sd_dq_in = 16'd0; sd_dqml = 1'b0; sd_dqmh = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 16'(ready), 16'd0);
        check("rst_cas_lat", 16'(cas_lat), 16'd2);
        check("rst_err", 16'(err), 16'd0);
        check("rst_refresh_cnt", refresh_cnt, 16'd0);
        check("rst_oe", 16'(sd_dq_oe), 16'd0);
        check("rst_dq_out", sd_dq_out, 16'd0);
        init_n = 1'b1;

        // init sequence
        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        nop(2);
        issue(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
        nop(8);
        issue(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
        nop(8);
        check("init_not_ready", 16'(ready), 16'd0);
        issue(C_MRS, 2'd0, 13'h220, 16'd0, 2'b00);
        check("init_ready", 16'(ready), 16'd1);
        check("init_cas_lat", 16'(cas_lat), 16'd2);
        check("init_err", 16'(err), 16'd0);
        check("init_refresh_cnt", refresh_cnt, 16'd2);
        nop(1);

        // CL2 write/read and byte masks
        issue(C_ACT, 2'd1, 13'd3, 16'd0, 2'b00);
        nop(1);
        issue(C_WR, 2'd1, 13'd5, 16'hA55A, 2'b00);
        rd(2'd1, 13'd5, 2'b00, 16'hA55A, 2);
        nop(3);
        issue(C_WR, 2'd1, 13'd5, 16'h1234, 2'b10);
        rd(2'd1, 13'd5, 2'b00, 16'hA534, 2);
        rd(2'd1, 13'd5, 2'b01, 16'hA534, 2);
        issue(C_WR, 2'd1, 13'd5, 16'h0F0F, 2'b00);
        nop(3);
        rd(2'd1, 13'd5, 2'b00, 16'h0F0F, 2);
        nop(3);

        // CL3 back-to-back
        issue(C_WR, 2'd1, 13'd0, 16'h1111, 2'b00);
        issue(C_WR, 2'd1, 13'd1, 16'h2222, 2'b00);
        issue(C_MRS, 2'd0, 13'h230, 16'd0, 2'b00);
        check("cl3_cas_lat", 16'(cas_lat), 16'd3);
        nop(1);
        rd(2'd1, 13'd0, 2'b00, 16'h1111, 3);
        rd(2'd1, 13'd1, 2'b00, 16'h2222, 3);
        nop(4);
        check("clean_err", 16'(err), 16'd0);

        // violations
        issue(C_ACT, 2'd2, 13'd0, 16'd0, 2'b00);
        nop(1);
        issue(C_WR, 2'd2, 13'd7, 16'h7777, 2'b00);
        issue(C_PRE, 2'd2, 13'd0, 16'd0, 2'b00);
        nop(1);
        issue(C_ACT, 2'd2, 13'd0, 16'd0, 2'b00);
        rd(2'd2, 13'd7, 2'b00, 16'h7777, 3);
        check("err_rcd", 16'(err), 16'b0010);
        nop(4);
        issue(C_ACT, 2'd2, 13'd0, 16'd0, 2'b00);
        check("err_open", 16'(err), 16'b0011);
        issue(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        nop(1);
        issue(C_REF, 2'd0, 13'd0, 16'd0, 2'b00);
        issue(C_ACT, 2'd0, 13'd0, 16'd0, 2'b00);
        check("err_rfc", 16'(err), 16'b0111);
        check("refresh_cnt_3", refresh_cnt, 16'd3);
        nop(8);
        check("err_sticky", 16'(err), 16'b0111);

        // async reset while read data is on the pins
        issue(C_RD, 2'd0, 13'd0, 16'd0, 2'b00);
        nop(2);
        check("mid_oe_before", 16'(sd_dq_oe), 16'b11);
        init_n = 1'b0;
        #1;
        check("mid_oe_async", 16'(sd_dq_oe), 16'd0);
        check("mid_ready_async", 16'(ready), 16'd0);
        check("mid_err_cleared", 16'(err), 16'd0);
        @(posedge clk);
        #1;
        init_n = 1'b1;
        issue(C_RD, 2'd0, 13'd0, 16'd0, 2'b00);
        check("pre_init_read_err", 16'(err), 16'b1000);
        nop(4);
        check("pre_init_read_oe", 16'(sd_dq_oe), 16'd0);
        nop(2);
        check("queue_drained", 16'(q.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
